// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-requester round-robin arbiter for the single-port data memory
// Optional requester bus lock for atomic read-modify-write: define DM_ARB_LOCK_EN.
module dm_arbiter #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              we1,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
`ifdef DM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_RD
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_t;

    lock_state_t       lock_state;
    lock_state_t       lock_next;
    logic              lk0;
    logic              lk1;
    logic              last_gnt;
    logic              can0;
    logic              can1;
    logic              sel_we;
    logic              illegal;
    logic [DATA_W-1:0] resp_data;

`ifdef DM_ARB_LOCK_EN
    assign lk0 = lock0;
    assign lk1 = lock1;
`else
    assign lk0 = 1'b0;
    assign lk1 = 1'b0;
`endif

    // Arbitration, memory port mux, legality and lock next-state.
    always_comb begin
        can0      = req0 && rst && (lock_state != LOCKED1);
        can1      = req1 && rst && (lock_state != LOCKED0);
        // last_gnt==1 means requester 1 was served last, so requester 0 wins a tie.
        gnt0      = can0 && (!can1 || last_gnt);
        gnt1      = can1 && (!can0 || !last_gnt);

        mem_address = gnt1 ? addr1  : addr0;
        mem_WD      = gnt1 ? wdata1 : wdata0;
        sel_we      = gnt1 ? we1    : we0;

        illegal   = (|mem_address[1:0]) ||
                    ((mem_address >> 2) >= DATA_W'(DEPTH_WORDS));
        mem_write = (gnt0 || gnt1) && sel_we && !illegal;
        resp_data = (illegal || sel_we) ? '0 : mem_RD;

        lock_next = lock_state;
        case (lock_state)
            UNLOCKED: begin
                if (gnt0 && lk0)
                    lock_next = LOCKED0;
                else if (gnt1 && lk1)
                    lock_next = LOCKED1;
            end
            LOCKED0: begin
                if (!lk0 && (gnt0 || !req0))
                    lock_next = UNLOCKED;
            end
            LOCKED1: begin
                if (!lk1 && (gnt1 || !req1))
                    lock_next = UNLOCKED;
            end
            default: lock_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_gnt   <= 1'b1;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            lock_state <= UNLOCKED;
        end else begin
            if (gnt0 || gnt1)
                last_gnt <= gnt1;
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            // Non-granted side keeps its last data/err; only rvalid drops.
            if (gnt0) begin
                rdata0 <= resp_data;
                err0   <= illegal;
            end
            if (gnt1) begin
                rdata1 <= resp_data;
                err1   <= illegal;
            end
            lock_state <= lock_next;
        end
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single-port data memory (Data_memory: word-addressed, combinational read, write on posedge clk) between requester 0 (CPU load/store stage) and requester 1 (DMA/debug loader).
- Grants at most one access per cycle, drives the memory port, and returns a registered response (read data, ack, error) to the granted requester one cycle later.
- Sits between the requesters and the memory instance.

Parameters:
- DATA_W, 32, data and address width in bits.
- DEPTH_WORDS, 100, number of valid memory words; addresses at or beyond DEPTH_WORDS*4 are out of range.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-low.
- req0  input  1  requester 0 access request; held until gnt0.
- we0  input  1  requester 0 write enable (1 = write, 0 = read).
- addr0  input  DATA_W  requester 0 byte address.
- wdata0  input  DATA_W  requester 0 write data.
- gnt0  output  1  requester 0 granted this cycle (combinational).
- rvalid0  output  1  requester 0 response valid (registered, 1-cycle pulse).
- rdata0  output  DATA_W  requester 0 read data, valid with rvalid0.
- err0  output  1  requester 0 out-of-range/misaligned flag, valid with rvalid0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, err1: same as above for requester 1.
- mem_address  output  DATA_W  byte address to memory.
- mem_WD  output  DATA_W  write data to memory.
- mem_write  output  1  memory write enable.
- mem_RD  input  DATA_W  memory read data (combinational).

Behaviour:
- Reset (rst==0 at posedge): last_gnt=1, so requester 0 wins first; rvalid0/1=0, rdata0/1=0, err0/1=0; lock state=UNLOCKED.
- While rst==0, gnt0=gnt1=0 and mem_write=0 combinationally, so no memory write can occur in the reset cycle.
- Arbitration, combinational each cycle:
  - Only one request asserted: grant it.
  - Both asserted: grant the one not equal to last_gnt.
  - At most one of gnt0/gnt1 is high.
  - last_gnt updates to the granted index at posedge; it is unchanged when there is no grant.
- Memory port:
  - mem_address, mem_WD and the write select follow the granted requester.
  - With no grant, these outputs mux requester 0's values and mem_write=0.
  - mem_write = granted we, and only when the access is legal.
- Legality:
  - Misaligned: addr[1:0]!=0.
  - Out of range: addr>>2 >= DEPTH_WORDS.
  - An illegal access is still granted (consumes the slot) but mem_write=0; the response returns rdata=0 and err=1.
- Response latency: 1 cycle.
  - At the posedge ending the grant cycle, rdata<granted> <= mem_RD (0 if illegal), err<granted> <= illegal, rvalid<granted> <= 1.
  - Writes also pulse rvalid as an ack; rdata is then 0.
  - Non-granted rvalid <= 0; its rdata/err hold their previous values.
- Back-to-back: a requester may keep req high after gnt; it can be granted on consecutive cycles only if the other requester is idle.
- Request rules: a requester must not change we/addr/wdata while req is high and gnt is low. Deassertion before grant is allowed and silently drops the request.
- Reset mid-operation: a grant in a cycle where rst==0 is suppressed; a response pending from the prior cycle is cleared at the reset posedge (no rvalid after reset).

Optional Feature:
- Macro: DM_ARB_LOCK_EN.
- Defined:
  - Inputs lock0, lock1 (1 bit each) are present.
  - State machine with states UNLOCKED, LOCKED0, LOCKED1:
    - UNLOCKED -> LOCKEDn when requester n is granted with lockn=1.
    - LOCKEDn -> UNLOCKED at a granted access by n with lockn=0, or at any posedge where reqn=0 and lockn=0.
    - In LOCKEDn only requester n can be granted; the other requester waits regardless of last_gnt.
  - Supports atomic read-modify-write.
  - Reset -> UNLOCKED.
- Undefined: lock ports are absent, the state stays UNLOCKED, and behaviour is pure round-robin.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req0=1, we0=1, addr0=0x8 -> gnt0=0, mem_write=0, rvalid0=0; word 2 unchanged.
- Single read: mem word 3=0xDEADBEEF; req0=1, we0=0, addr0=0xC for 1 cycle -> gnt0=1 that cycle; next cycle rvalid0=1, rdata0=0xDEADBEEF, err0=0.
- Contention: req0=req1=1 (both reads) for 4 cycles after reset -> gnt sequence 0,1,0,1; rvalid pulses alternate one cycle later.
- Write then read: requester 1 writes 0x12345678 to 0x10, then reads 0x10 -> ack rvalid1 with rdata1=0; read returns 0x12345678.
- Illegal: addr0=0x190 (word 100, write) and addr1=0x6 (misaligned read) -> both granted in turn, mem_write=0, err=1, rdata=0; memory unchanged.
- DM_ARB_LOCK_EN: requester 0 reads 0x4 with lock0=1 while req1=1; then writes 0x4 with lock0=0 -> gnt1 stays 0 until after the write is granted; the next cycle grants requester 1.
